// File: rtl/decoder3_8_seq.sv
// decoder3_8_seq: registered 3-to-8 one-hot decoder with a valid/ready input
// handshake. When DECODER3_8_SCAN_EN is defined, the block also has a self-timed
// scan mode. In that mode the one-hot output walks 0..7 and holds each position
// for dwell+1 cycles.
module decoder3_8_seq #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic [2:0]         in_code,
    output logic               in_ready,
    input  logic               scan,
    input  logic [DWELL_W-1:0] dwell,
    output logic [7:0]         out,
    output logic               out_valid,
    output logic               scan_done
);

`ifdef DECODER3_8_SCAN_EN

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

    state_t             state;
    logic [DWELL_W-1:0] dwell_lat;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [2:0]         scan_idx;
    logic               transfer;

    assign in_ready = en && (state != SCAN);
    assign transfer = in_valid && in_ready;

    // Main state machine: disable beats a transfer, and a transfer beats a scan request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out       <= 8'h00;
            out_valid <= 1'b0;
            scan_done <= 1'b0;
            dwell_lat <= '0;
            dwell_cnt <= '0;
            scan_idx  <= 3'd0;
        end else begin
            scan_done <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                out       <= 8'h00;
                out_valid <= 1'b0;
                dwell_cnt <= '0;
                scan_idx  <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (transfer) begin
                            out       <= 8'h01 << in_code;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else if (scan) begin
                            dwell_lat <= dwell;
                            dwell_cnt <= '0;
                            scan_idx  <= 3'd0;
                            out       <= 8'h01;
                            out_valid <= 1'b1;
                            state     <= SCAN;
                        end
                    end
                    HOLD: begin
                        if (transfer) begin
                            out       <= 8'h01 << in_code;
                            out_valid <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (!scan) begin
                            out       <= 8'h00;
                            out_valid <= 1'b0;
                            dwell_cnt <= '0;
                            scan_idx  <= 3'd0;
                            state     <= IDLE;
                        end else if (dwell_cnt == dwell_lat) begin
                            dwell_cnt <= '0;
                            if (scan_idx == 3'd7) begin
                                out       <= 8'h00;
                                out_valid <= 1'b0;
                                scan_done <= 1'b1;
                                scan_idx  <= 3'd0;
                                state     <= IDLE;
                            end else begin
                                scan_idx <= scan_idx + 3'd1;
                                out      <= 8'h01 << (scan_idx + 3'd1);
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        out       <= 8'h00;
                        out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

`else

    typedef enum logic [0:0] {IDLE, HOLD} state_t;

    state_t state;
    logic   transfer;
    logic   scan_inputs_unused;

    assign in_ready           = en;
    assign transfer           = in_valid && in_ready;
    assign scan_done          = 1'b0;
    assign scan_inputs_unused = ^{scan, dwell};

    // Pure handshaked decoder: disable clears, and a transfer loads a new one-hot value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out       <= 8'h00;
            out_valid <= 1'b0;
        end else if (!en) begin
            state     <= IDLE;
            out       <= 8'h00;
            out_valid <= 1'b0;
        end else if (transfer) begin
            out       <= 8'h01 << in_code;
            out_valid <= 1'b1;
            state     <= HOLD;
        end
    end

`endif

endmodule

// File: tb/tb_decoder3_8_seq.sv
// tb_decoder3_8_seq: scoreboard bench for decoder3_8_seq.
// The driver steps a behavioural model and queues the expected outputs for each edge.
// A separate monitor pops the queue one cycle later and compares.
module tb_decoder3_8_seq;

    localparam int DWELL_W = 4;
`ifdef DECODER3_8_SCAN_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               in_valid = 1'b0;
    logic [2:0]         in_code = 3'd0;
    logic               in_ready;
    logic               scan = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [7:0]         out;
    logic               out_valid;
    logic               scan_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] out;
        logic       valid;
        logic       done;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    // Model state: 0 = idle, 1 = hold, 2 = scan
    int         m_mode = 0;
    logic [7:0] m_out = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_done = 1'b0;
    int         m_t = 0;
    int         m_dwell = 0;

    decoder3_8_seq #(.DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .scan(scan), .dwell(dwell), .out(out),
        .out_valid(out_valid), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // The model describes scan in terms of elapsed cycles: position = elapsed / (dwell + 1)
    task automatic modelStep(input logic e, input logic iv, input logic [2:0] code,
                             input logic sc, input int dw);
        int pos;
        m_done = 1'b0;
        if (!e) begin
            m_mode = 0; m_out = 8'h00; m_valid = 1'b0;
        end else if (m_mode != 2 && iv) begin
            m_mode = 1; m_out = 8'h01 << code; m_valid = 1'b1;
        end else if (m_mode == 0 && sc && SCAN_ON) begin
            m_mode = 2; m_dwell = dw; m_t = 0; m_out = 8'h01; m_valid = 1'b1;
        end else if (m_mode == 2) begin
            if (!sc) begin
                m_mode = 0; m_out = 8'h00; m_valid = 1'b0;
            end else begin
                m_t = m_t + 1;
                pos = m_t / (m_dwell + 1);
                if (pos >= 8) begin
                    m_mode = 0; m_out = 8'h00; m_valid = 1'b0; m_done = 1'b1;
                end else begin
                    m_out = 8'h01 << pos;
                end
            end
        end
    endtask

    task automatic modelReset();
        m_mode = 0; m_out = 8'h00; m_valid = 1'b0; m_done = 1'b0; m_t = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] eo,
                               input logic ev, input logic ed);
        checks++;
        if (out !== eo || out_valid !== ev || scan_done !== ed) begin
            failures++;
            $display("[TB] FAIL %s: got out=%h valid=%b done=%b, expected out=%h valid=%b done=%b",
                     tag, out, out_valid, scan_done, eo, ev, ed);
        end
    endtask

    // Drive one cycle of inputs, check in_ready, advance the model and queue the expected result
    task automatic applyStimulus(input string tag, input logic e, input logic iv,
                                 input logic [2:0] code, input logic sc, input int dw);
        exp_t x;
        logic exp_ready;
        @(negedge clk);
        en = e; in_valid = iv; in_code = code; scan = sc; dwell = DWELL_W'(dw);
        #1;
        exp_ready = e && (m_mode != 2);
        checks++;
        if (in_ready !== exp_ready) begin
            failures++;
            $display("[TB] FAIL %s in_ready: got %b, expected %b", tag, in_ready, exp_ready);
        end
        modelStep(e, iv, code, sc, dw);
        x.out = m_out; x.valid = m_valid; x.done = m_done; x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Monitor: after each rising edge, compare the registered outputs with the oldest expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput(x.tag, x.out, x.valid, x.done);
                checks++;
                if (!((out == 8'h00 || $onehot(out)) && out_valid == (out != 8'h00))) begin
                    failures++;
                    $display("[TB] FAIL invariant: got out=%h valid=%b, expected zero/one-hot with matching valid",
                             out, out_valid);
                end
            end
        end
    end

    initial begin
        // Reset state
        #2;
        checkOutput("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();

        // Decode sweep
        for (int i = 0; i < 8; i++) applyStimulus("sweep", 1'b1, 1'b1, 3'(i), 1'b0, 0);

        // Disable: code 5 held, then en dropped with a transfer attempt
        applyStimulus("hold5", 1'b1, 1'b1, 3'd5, 1'b0, 0);
        applyStimulus("hold5b", 1'b1, 1'b0, 3'd5, 1'b0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("disabled", 1'b0, 1'b1, 3'd2, 1'b0, 0);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            applyStimulus("random", ($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                          3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 3));
        end
        applyStimulus("toidle", 1'b0, 1'b0, 3'd0, 1'b0, 0);

`ifdef DECODER3_8_SCAN_EN
        // Full scan with dwell 2
        for (int i = 0; i < 27; i++) applyStimulus("scan_d2", 1'b1, 1'b0, 3'd0, 1'b1, 2);
        applyStimulus("scan_off", 1'b1, 1'b0, 3'd0, 1'b0, 0);

        // Scan lockout and abort at 8'h08
        applyStimulus("abort_entry", 1'b1, 1'b0, 3'd0, 1'b1, 0);
        for (int i = 0; i < 3; i++) applyStimulus("lockout", 1'b1, 1'b1, 3'd3, 1'b1, 0);
        applyStimulus("abort", 1'b1, 1'b0, 3'd0, 1'b0, 0);

        // Async reset mid-scan at 8'h40
        applyStimulus("ar_entry", 1'b1, 1'b0, 3'd0, 1'b1, 1);
        for (int i = 0; i < 12; i++) applyStimulus("ar_walk", 1'b1, 1'b0, 3'd0, 1'b1, 1);
        @(posedge clk);
        #3;
        checkOutput("pre_async_reset", 8'h40, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 8'h00, 1'b0, 1'b0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("post_reset", 1'b1, 1'b1, 3'd6, 1'b0, 0);
`else
        // Scan request is ignored without the scan feature
        for (int i = 0; i < 6; i++) applyStimulus("noscan", 1'b1, 1'b0, 3'd0, 1'b1, 1);
        for (int i = 0; i < 8; i++) applyStimulus("sweep2", 1'b1, 1'b1, 3'(i), 1'b1, 0);
`endif

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
